load_dcache_port: RTL and testbench

- Sits directly downstream of the load buffer, which issues one load request per cycle.
- Accepts each request with a same-cycle success strobe and forwards it to the data-memory/cache request channel.
- Tracks up to DEPTH outstanding loads in order and returns each response to the load buffer tagged with its load-buffer pointer.
- Enforces strongly-ordered (uncached) load ordering and discards responses belonging to flushed loads.

---
 rtl/load_dcache_port_if.sv | 50 +++++
 rtl/load_dcache_port.sv | 152 +++++++++++++++
 tb/tb_load_dcache_port.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_dcache_port_if.sv
// Bundles the load-buffer request/return signals and the data-memory
// request/response channel of the load data-cache port.
//
// Signals
//   LdFlash          pipeline flush from the core
//   LbToDcdAble      load request valid from the load buffer
//   LbToDcdAMat      memory access type (2'b00 strongly-ordered uncached)
//   LbToDcdAPtr      load-buffer entry index of the request
//   LbToDcdAPhyAddr  physical address of the request
//   DcdToLbSuccess   same-cycle acceptance strobe back to the load buffer
//   DcdToLbBackAble  registered load-return valid
//   DcdToLbBackPtr   load-buffer entry index of the returned load
//   DcdToLbBackDate  returned load word
//   MemReqValid/MemReqReady/MemReqAddr/MemReqUncache  memory request channel
//   MemRespValid/MemRespData                          in-order memory response
//
// Modports
//   slave   the load dcache port itself
//   master  the surrounding environment (load buffer plus memory)
interface load_dcache_port_if;
   logic        LdFlash;
   logic        LbToDcdAble;
   logic [1:0]  LbToDcdAMat;
   logic [2:0]  LbToDcdAPtr;
   logic [31:0] LbToDcdAPhyAddr;
   logic        DcdToLbSuccess;
   logic        DcdToLbBackAble;
   logic [2:0]  DcdToLbBackPtr;
   logic [31:0] DcdToLbBackDate;
   logic        MemReqValid;
   logic        MemReqReady;
   logic [31:0] MemReqAddr;
   logic        MemReqUncache;
   logic        MemRespValid;
   logic [31:0] MemRespData;

   modport slave (
      input  LdFlash, LbToDcdAble, LbToDcdAMat, LbToDcdAPtr, LbToDcdAPhyAddr,
      input  MemReqReady, MemRespValid, MemRespData,
      output DcdToLbSuccess, DcdToLbBackAble, DcdToLbBackPtr, DcdToLbBackDate,
      output MemReqValid, MemReqAddr, MemReqUncache
   );

   modport master (
      output LdFlash, LbToDcdAble, LbToDcdAMat, LbToDcdAPtr, LbToDcdAPhyAddr,
      output MemReqReady, MemRespValid, MemRespData,
      input  DcdToLbSuccess, DcdToLbBackAble, DcdToLbBackPtr, DcdToLbBackDate,
      input  MemReqValid, MemReqAddr, MemReqUncache
   );
endinterface

// File: rtl/load_dcache_port.sv
// Load data-cache port. Accepts one load per cycle from the load buffer,
// forwards it to the memory request channel, remembers the load-buffer
// pointer of every outstanding load in order, and returns each in-order
// memory response tagged with its pointer one cycle later. Strongly-ordered
// (uncached) loads are only issued when nothing else is in flight and block
// all later loads until their own response is back. A flush turns every live
// outstanding load into a "drop" so its response is silently discarded.
//
// Ports
//   Clk   clock
//   Rest  asynchronous active-low reset
//   bus   load_dcache_port_if.slave: load-buffer and memory channels
//
// Parameters
//   DEPTH  maximum outstanding loads (live plus being dropped), power of two
//   CNTW   width of the outstanding/drop counters, holds 0..DEPTH
module load_dcache_port #(
   parameter int DEPTH = 4,
   parameter int CNTW  = 3
) (
   input logic              Clk,
   input logic              Rest,
   load_dcache_port_if.slave bus
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNTW:0] DepthLimit = (CNTW+1)'(DEPTH);

   logic [2:0]       ptrFifo [DEPTH];
   logic [DEPTH-1:0] ucFifo;
   logic [AW-1:0]    wrIdx;
   logic [AW-1:0]    rdIdx;
   logic [CNTW-1:0]  OutCnt;
   logic [CNTW-1:0]  DropCnt;
   logic             UcPending;

   logic             backAble;
   logic [2:0]       backPtr;
   logic [31:0]      backDate;

   logic [CNTW:0]    inFlight;
   logic             isUncached;
   logic             gate;
   logic             reqValid;
   logic             accept;
   logic             livePop;
   logic             dropPop;
   logic             anyPop;

   // Admission gate works purely on registered counts, so a response that
   // frees a slot only opens the gate on the following cycle. An uncached
   // load additionally waits until the port is completely idle.
   always_comb begin
      inFlight   = {1'b0, OutCnt} + {1'b0, DropCnt};
      isUncached = (bus.LbToDcdAMat == 2'b00);
      gate       = ~bus.LdFlash
                 & (inFlight < DepthLimit)
                 & ~UcPending
                 & ~(isUncached & (inFlight != '0));
      reqValid   = bus.LbToDcdAble & gate;
      accept     = reqValid & bus.MemReqReady;
   end

   // Responses come back in issue order: the oldest in-flight loads are the
   // dropped ones, so they consume responses before any live FIFO entry.
   // A response with nothing outstanding matches neither term and is ignored.
   always_comb begin
      dropPop = bus.MemRespValid & (DropCnt != '0);
      livePop = bus.MemRespValid & (DropCnt == '0) & (OutCnt != '0);
      anyPop  = dropPop | livePop;
   end

   assign bus.MemReqValid     = reqValid;
   assign bus.MemReqAddr      = bus.LbToDcdAPhyAddr;
   assign bus.MemReqUncache   = isUncached;
   assign bus.DcdToLbSuccess  = accept;
   assign bus.DcdToLbBackAble = backAble;
   assign bus.DcdToLbBackPtr  = backPtr;
   assign bus.DcdToLbBackDate = backDate;

   // Pointer FIFO, counters and uncached-pending flag. On a flush every live
   // entry is moved into the drop count (less one if a response arrives in
   // that same cycle) and the FIFO restarts empty. No accept can coincide
   // with a flush because the gate excludes it.
   always_ff @(posedge Clk or negedge Rest) begin
      if (!Rest) begin
         for (int i = 0; i < DEPTH; i++) begin
            ptrFifo[i] <= '0;
         end
         ucFifo    <= '0;
         wrIdx     <= '0;
         rdIdx     <= '0;
         OutCnt    <= '0;
         DropCnt   <= '0;
         UcPending <= 1'b0;
      end else if (bus.LdFlash) begin
         DropCnt   <= DropCnt + OutCnt - CNTW'(anyPop);
         OutCnt    <= '0;
         wrIdx     <= '0;
         rdIdx     <= '0;
         UcPending <= 1'b0;
      end else begin
         if (accept) begin
            ptrFifo[wrIdx] <= bus.LbToDcdAPtr;
            ucFifo[wrIdx]  <= isUncached;
            wrIdx          <= wrIdx + 1'b1;
         end
         if (livePop) begin
            rdIdx <= rdIdx + 1'b1;
         end
         if (dropPop) begin
            DropCnt <= DropCnt - 1'b1;
         end
         case ({accept, livePop})
            2'b10:   OutCnt <= OutCnt + 1'b1;
            2'b01:   OutCnt <= OutCnt - 1'b1;
            default: OutCnt <= OutCnt;
         endcase
         if (livePop && ucFifo[rdIdx]) begin
            UcPending <= 1'b0;
         end
         if (accept && isUncached) begin
            UcPending <= 1'b1;
         end
      end
   end

   // Registered return path. A pop in a flush cycle is suppressed, and the
   // pointer/data are held at zero whenever no return is signalled.
   always_ff @(posedge Clk or negedge Rest) begin
      if (!Rest) begin
         backAble <= 1'b0;
         backPtr  <= '0;
         backDate <= '0;
      end else if (livePop && !bus.LdFlash) begin
         backAble <= 1'b1;
         backPtr  <= ptrFifo[rdIdx];
         backDate <= bus.MemRespData;
      end else begin
         backAble <= 1'b0;
         backPtr  <= '0;
         backDate <= '0;
      end
   end

   // A memory response with nothing outstanding is a protocol violation.
   respWithoutLoad: assert property (
      @(posedge Clk) disable iff (!Rest)
      !(bus.MemRespValid && (OutCnt == '0) && (DropCnt == '0))
   );

endmodule

// File: tb/tb_load_dcache_port.sv
// Directed self-checking bench for load_dcache_port (DEPTH=4). Inputs are
// driven one time unit after each rising edge; combinational outputs are
// checked a further unit later and registered outputs right after the edge.
module tb_load_dcache_port;

   logic Clk;
   logic Rest;
   int   checks;
   int   errors;

   load_dcache_port_if bus ();

   load_dcache_port #(.DEPTH(4), .CNTW(3)) dut (
      .Clk  (Clk),
      .Rest (Rest),
      .bus  (bus.slave)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Drive every DUT input for the coming cycle; address is derived from ptr.
   task automatic applyStimulus(input logic able, input logic [1:0] mat,
                                input logic [2:0] ptr, input logic ready,
                                input logic resp, input logic [31:0] data,
                                input logic flush);
      bus.LbToDcdAble     = able;
      bus.LbToDcdAMat     = mat;
      bus.LbToDcdAPtr     = ptr;
      bus.LbToDcdAPhyAddr = {16'hA000, 12'h000, 1'b0, ptr};
      bus.MemReqReady     = ready;
      bus.MemRespValid    = resp;
      bus.MemRespData     = data;
      bus.LdFlash         = flush;
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 2'b01, 3'd0, 1'b1, 1'b0, 32'h0, 1'b0);
   endtask

   // Reset state, asynchronous reset in the middle of traffic, and a clean
   // empty state afterwards (an uncached load is admitted at once).
   task automatic test_reset();
      Rest = 1'b0;
      idle();
      repeat (2) @(posedge Clk);
      #1;
      checks++;
      if ({bus.DcdToLbBackAble, bus.DcdToLbBackPtr, bus.DcdToLbBackDate,
           bus.MemReqValid, bus.DcdToLbSuccess} !== 38'h0) begin
         errors++;
         $display("[TB] FAIL reset_outputs got able=%0b ptr=%0d data=%h mv=%0b succ=%0b required all 0",
                  bus.DcdToLbBackAble, bus.DcdToLbBackPtr, bus.DcdToLbBackDate,
                  bus.MemReqValid, bus.DcdToLbSuccess);
      end
      Rest = 1'b1;
      step();
      for (int i = 1; i <= 3; i++) begin
         applyStimulus(1'b1, 2'b01, 3'(i), 1'b1, 1'b0, 32'h0, 1'b0);
         step();
      end
      applyStimulus(1'b0, 2'b01, 3'd0, 1'b1, 1'b1, 32'h55, 1'b0);
      step();
      idle();
      checks++;
      if ({bus.DcdToLbBackAble, bus.DcdToLbBackPtr, bus.DcdToLbBackDate} !== {1'b1, 3'd1, 32'h55}) begin
         errors++;
         $display("[TB] FAIL pre_reset_return got able=%0b ptr=%0d data=%h required 1/1/00000055",
                  bus.DcdToLbBackAble, bus.DcdToLbBackPtr, bus.DcdToLbBackDate);
      end
      #2;
      Rest = 1'b0;
      #1;
      checks++;
      if ({bus.DcdToLbBackAble, bus.DcdToLbBackPtr, bus.DcdToLbBackDate} !== 36'h0) begin
         errors++;
         $display("[TB] FAIL async_reset got able=%0b ptr=%0d data=%h required 0/0/0",
                  bus.DcdToLbBackAble, bus.DcdToLbBackPtr, bus.DcdToLbBackDate);
      end
      step();
      Rest = 1'b1;
      applyStimulus(1'b1, 2'b00, 3'd6, 1'b1, 1'b0, 32'h0, 1'b0);
      #1;
      checks++;
      if ({bus.MemReqValid, bus.DcdToLbSuccess, bus.MemReqUncache} !== 3'b111 ||
          bus.MemReqAddr !== 32'hA000_0006) begin
         errors++;
         $display("[TB] FAIL post_reset_uc_accept got mv=%0b succ=%0b uc=%0b addr=%h required 1/1/1/a0000006",
                  bus.MemReqValid, bus.DcdToLbSuccess, bus.MemReqUncache, bus.MemReqAddr);
      end
      step();
      applyStimulus(1'b0, 2'b01, 3'd0, 1'b1, 1'b1, 32'h66, 1'b0);
      step();
      idle();
      checks++;
      if ({bus.DcdToLbBackAble, bus.DcdToLbBackPtr, bus.DcdToLbBackDate} !== {1'b1, 3'd6, 32'h66}) begin
         errors++;
         $display("[TB] FAIL post_reset_uc_return got able=%0b ptr=%0d data=%h required 1/6/00000066",
                  bus.DcdToLbBackAble, bus.DcdToLbBackPtr, bus.DcdToLbBackDate);
      end
      step();
   endtask

   // Three cached loads returned in order with one-cycle latency.
   task automatic test_cached();
      logic [2:0]  ptrs [3];
      logic [31:0] datas [3];
      ptrs  = '{3'd2, 3'd5, 3'd7};
      datas = '{32'hA, 32'hB, 32'hC};
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 2'b01, ptrs[i], 1'b1, 1'b0, 32'h0, 1'b0);
         #1;
         checks++;
         if (bus.DcdToLbSuccess !== 1'b1 || bus.MemReqUncache !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cached_accept%0d got succ=%0b uc=%0b required 1/0",
                     i, bus.DcdToLbSuccess, bus.MemReqUncache);
         end
         step();
      end
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 2'b01, 3'd0, 1'b1, 1'b1, datas[i], 1'b0);
         if (i == 0) begin
            #1;
            checks++;
            if (bus.DcdToLbBackAble !== 1'b0) begin
               errors++;
               $display("[TB] FAIL cached_latency got able=%0b required 0", bus.DcdToLbBackAble);
            end
         end
         step();
         checks++;
         if ({bus.DcdToLbBackAble, bus.DcdToLbBackPtr, bus.DcdToLbBackDate} !== {1'b1, ptrs[i], datas[i]}) begin
            errors++;
            $display("[TB] FAIL cached_return%0d got able=%0b ptr=%0d data=%h required 1/%0d/%h",
                     i, bus.DcdToLbBackAble, bus.DcdToLbBackPtr, bus.DcdToLbBackDate, ptrs[i], datas[i]);
         end
      end
      idle();
      step();
      checks++;
      if ({bus.DcdToLbBackAble, bus.DcdToLbBackPtr, bus.DcdToLbBackDate} !== 36'h0) begin
         errors++;
         $display("[TB] FAIL cached_quiet got able=%0b ptr=%0d data=%h required 0/0/0",
                  bus.DcdToLbBackAble, bus.DcdToLbBackPtr, bus.DcdToLbBackDate);
      end
   endtask

   // Fill to DEPTH, confirm the block holds through a same-cycle response,
   // then drain across the FIFO wrap.
   task automatic test_full();
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(1'b1, 2'b01, 3'(i), 1'b1, 1'b0, 32'h0, 1'b0);
         step();
      end
      applyStimulus(1'b1, 2'b01, 3'd5, 1'b1, 1'b0, 32'h0, 1'b0);
      #1;
      checks++;
      if ({bus.MemReqValid, bus.DcdToLbSuccess} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL full_block got mv=%0b succ=%0b required 0/0",
                  bus.MemReqValid, bus.DcdToLbSuccess);
      end
      step();
      applyStimulus(1'b1, 2'b01, 3'd5, 1'b1, 1'b1, 32'h11, 1'b0);
      #1;
      checks++;
      if (bus.MemReqValid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL full_same_cycle got mv=%0b required 0", bus.MemReqValid);
      end
      step();
      checks++;
      if ({bus.DcdToLbBackAble, bus.DcdToLbBackPtr, bus.DcdToLbBackDate} !== {1'b1, 3'd1, 32'h11}) begin
         errors++;
         $display("[TB] FAIL full_first_return got able=%0b ptr=%0d data=%h required 1/1/00000011",
                  bus.DcdToLbBackAble, bus.DcdToLbBackPtr, bus.DcdToLbBackDate);
      end
      applyStimulus(1'b1, 2'b01, 3'd5, 1'b1, 1'b0, 32'h0, 1'b0);
      #1;
      checks++;
      if ({bus.MemReqValid, bus.DcdToLbSuccess} !== 2'b11) begin
         errors++;
         $display("[TB] FAIL full_unblock got mv=%0b succ=%0b required 1/1",
                  bus.MemReqValid, bus.DcdToLbSuccess);
      end
      step();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 2'b01, 3'd0, 1'b1, 1'b1, 32'h12 + 32'(i), 1'b0);
         step();
         checks++;
         if ({bus.DcdToLbBackAble, bus.DcdToLbBackPtr, bus.DcdToLbBackDate} !==
             {1'b1, 3'(i + 2), 32'h12 + 32'(i)}) begin
            errors++;
            $display("[TB] FAIL full_drain%0d got able=%0b ptr=%0d data=%h required 1/%0d/%h",
                     i, bus.DcdToLbBackAble, bus.DcdToLbBackPtr, bus.DcdToLbBackDate, i + 2, 32'h12 + 32'(i));
         end
      end
      idle();
      step();
   endtask

   // Uncached waits for an idle port, then blocks a following cached load
   // until its own response has been consumed.
   task automatic test_uncached();
      applyStimulus(1'b1, 2'b01, 3'd1, 1'b1, 1'b0, 32'h0, 1'b0);
      step();
      applyStimulus(1'b1, 2'b00, 3'd3, 1'b1, 1'b0, 32'h0, 1'b0);
      #1;
      checks++;
      if ({bus.MemReqValid, bus.DcdToLbSuccess} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL uc_wait_idle got mv=%0b succ=%0b required 0/0",
                  bus.MemReqValid, bus.DcdToLbSuccess);
      end
      step();
      applyStimulus(1'b1, 2'b00, 3'd3, 1'b1, 1'b1, 32'h21, 1'b0);
      #1;
      checks++;
      if (bus.MemReqValid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL uc_wait_resp_cycle got mv=%0b required 0", bus.MemReqValid);
      end
      step();
      applyStimulus(1'b1, 2'b00, 3'd3, 1'b1, 1'b0, 32'h0, 1'b0);
      #1;
      checks++;
      if ({bus.MemReqValid, bus.DcdToLbSuccess, bus.MemReqUncache} !== 3'b111) begin
         errors++;
         $display("[TB] FAIL uc_accept got mv=%0b succ=%0b uc=%0b required 1/1/1",
                  bus.MemReqValid, bus.DcdToLbSuccess, bus.MemReqUncache);
      end
      step();
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, 2'b01, 3'd4, 1'b1, 1'b0, 32'h0, 1'b0);
         #1;
         checks++;
         if ({bus.MemReqValid, bus.DcdToLbSuccess} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL uc_blocks_cached%0d got mv=%0b succ=%0b required 0/0",
                     i, bus.MemReqValid, bus.DcdToLbSuccess);
         end
         step();
      end
      applyStimulus(1'b1, 2'b01, 3'd4, 1'b1, 1'b1, 32'h33, 1'b0);
      #1;
      checks++;
      if (bus.MemReqValid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL uc_release_cycle got mv=%0b required 0", bus.MemReqValid);
      end
      step();
      checks++;
      if ({bus.DcdToLbBackAble, bus.DcdToLbBackPtr, bus.DcdToLbBackDate} !== {1'b1, 3'd3, 32'h33}) begin
         errors++;
         $display("[TB] FAIL uc_return got able=%0b ptr=%0d data=%h required 1/3/00000033",
                  bus.DcdToLbBackAble, bus.DcdToLbBackPtr, bus.DcdToLbBackDate);
      end
      applyStimulus(1'b1, 2'b01, 3'd4, 1'b1, 1'b0, 32'h0, 1'b0);
      #1;
      checks++;
      if (bus.DcdToLbSuccess !== 1'b1) begin
         errors++;
         $display("[TB] FAIL uc_cached_after got succ=%0b required 1", bus.DcdToLbSuccess);
      end
      step();
      applyStimulus(1'b0, 2'b01, 3'd0, 1'b1, 1'b1, 32'h44, 1'b0);
      step();
      idle();
      checks++;
      if ({bus.DcdToLbBackAble, bus.DcdToLbBackPtr} !== {1'b1, 3'd4}) begin
         errors++;
         $display("[TB] FAIL uc_cached_return got able=%0b ptr=%0d required 1/4",
                  bus.DcdToLbBackAble, bus.DcdToLbBackPtr);
      end
      step();
   endtask

   // Flush turns live loads into drops; later loads map past the drops.
   task automatic test_flush();
      applyStimulus(1'b1, 2'b01, 3'd1, 1'b1, 1'b0, 32'h0, 1'b0);
      step();
      applyStimulus(1'b1, 2'b01, 3'd2, 1'b1, 1'b0, 32'h0, 1'b0);
      step();
      applyStimulus(1'b1, 2'b01, 3'd6, 1'b1, 1'b0, 32'h0, 1'b1);
      #1;
      checks++;
      if ({bus.MemReqValid, bus.DcdToLbSuccess} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL flush_no_accept got mv=%0b succ=%0b required 0/0",
                  bus.MemReqValid, bus.DcdToLbSuccess);
      end
      step();
      checks++;
      if (bus.DcdToLbBackAble !== 1'b0 || dut.DropCnt !== 3'd2) begin
         errors++;
         $display("[TB] FAIL flush_dropcnt got able=%0b drop=%0d required 0/2",
                  bus.DcdToLbBackAble, dut.DropCnt);
      end
      applyStimulus(1'b1, 2'b01, 3'd4, 1'b1, 1'b0, 32'h0, 1'b0);
      #1;
      checks++;
      if (bus.DcdToLbSuccess !== 1'b1) begin
         errors++;
         $display("[TB] FAIL flush_new_accept got succ=%0b required 1", bus.DcdToLbSuccess);
      end
      step();
      for (int i = 1; i <= 3; i++) begin
         applyStimulus(1'b0, 2'b01, 3'd0, 1'b1, 1'b1, 32'(i), 1'b0);
         step();
         checks++;
         if (i < 3 && bus.DcdToLbBackAble !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_discard%0d got able=%0b required 0", i, bus.DcdToLbBackAble);
         end else if (i == 3 && {bus.DcdToLbBackAble, bus.DcdToLbBackPtr, bus.DcdToLbBackDate} !==
                      {1'b1, 3'd4, 32'h3}) begin
            errors++;
            $display("[TB] FAIL flush_survivor got able=%0b ptr=%0d data=%h required 1/4/00000003",
                     bus.DcdToLbBackAble, bus.DcdToLbBackPtr, bus.DcdToLbBackDate);
         end
      end
      // Flush coinciding with a live pop: the return is suppressed and the
      // popped load is not counted as a drop.
      applyStimulus(1'b1, 2'b01, 3'd5, 1'b1, 1'b0, 32'h0, 1'b0);
      step();
      applyStimulus(1'b0, 2'b01, 3'd0, 1'b1, 1'b1, 32'h77, 1'b1);
      step();
      checks++;
      if (bus.DcdToLbBackAble !== 1'b0) begin
         errors++;
         $display("[TB] FAIL flush_pop_suppressed got able=%0b required 0", bus.DcdToLbBackAble);
      end
      applyStimulus(1'b1, 2'b01, 3'd6, 1'b1, 1'b0, 32'h0, 1'b0);
      step();
      applyStimulus(1'b0, 2'b01, 3'd0, 1'b1, 1'b1, 32'h88, 1'b0);
      step();
      idle();
      checks++;
      if ({bus.DcdToLbBackAble, bus.DcdToLbBackPtr, bus.DcdToLbBackDate} !== {1'b1, 3'd6, 32'h88}) begin
         errors++;
         $display("[TB] FAIL flush_pop_nodrop got able=%0b ptr=%0d data=%h required 1/6/00000088",
                  bus.DcdToLbBackAble, bus.DcdToLbBackPtr, bus.DcdToLbBackDate);
      end
      step();
   endtask

   // Back-pressure leaves state untouched; accept plus pop in the same cycle
   // keeps the count steady while the FIFO indices wrap.
   task automatic test_back_to_back();
      applyStimulus(1'b1, 2'b01, 3'd2, 1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      checks++;
      if ({bus.MemReqValid, bus.DcdToLbSuccess} !== 2'b10) begin
         errors++;
         $display("[TB] FAIL ready_low got mv=%0b succ=%0b required 1/0",
                  bus.MemReqValid, bus.DcdToLbSuccess);
      end
      repeat (2) step();
      applyStimulus(1'b1, 2'b00, 3'd2, 1'b1, 1'b0, 32'h0, 1'b0);
      #1;
      checks++;
      if (bus.DcdToLbSuccess !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ready_low_no_state got succ=%0b required 1", bus.DcdToLbSuccess);
      end
      step();
      applyStimulus(1'b0, 2'b01, 3'd0, 1'b1, 1'b1, 32'h99, 1'b0);
      step();
      applyStimulus(1'b1, 2'b01, 3'd1, 1'b1, 1'b0, 32'h0, 1'b0);
      step();
      for (int k = 0; k < 6; k++) begin
         applyStimulus(1'b1, 2'b01, 3'(k + 2), 1'b1, 1'b1, 32'h100 + 32'(k), 1'b0);
         #1;
         checks++;
         if (bus.DcdToLbSuccess !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_accept%0d got succ=%0b required 1", k, bus.DcdToLbSuccess);
         end
         step();
         checks++;
         if ({bus.DcdToLbBackAble, bus.DcdToLbBackPtr, bus.DcdToLbBackDate} !==
             {1'b1, 3'(k + 1), 32'h100 + 32'(k)} || dut.OutCnt !== 3'd1) begin
            errors++;
            $display("[TB] FAIL b2b_return%0d got able=%0b ptr=%0d data=%h out=%0d required 1/%0d/%h/1",
                     k, bus.DcdToLbBackAble, bus.DcdToLbBackPtr, bus.DcdToLbBackDate, dut.OutCnt,
                     k + 1, 32'h100 + 32'(k));
         end
      end
      applyStimulus(1'b0, 2'b01, 3'd0, 1'b1, 1'b1, 32'h200, 1'b0);
      step();
      idle();
      checks++;
      if ({bus.DcdToLbBackAble, bus.DcdToLbBackPtr, bus.DcdToLbBackDate} !== {1'b1, 3'd7, 32'h200}) begin
         errors++;
         $display("[TB] FAIL b2b_last got able=%0b ptr=%0d data=%h required 1/7/00000200",
                  bus.DcdToLbBackAble, bus.DcdToLbBackPtr, bus.DcdToLbBackDate);
      end
      step();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_cached();
      test_full();
      test_uncached();
      test_flush();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
